neuron_mac_stream: RTL

// - Next-generation RAM-backed neuron for the NN layer fabric: one dot product plus bias, then activation, result written to the output-activation RAM.
// - Holds both input mutexes for the whole accumulation and streams one input per cycle. Uses a private multiplier; there is no shared-multiplier arbitration.
// - Adds signed fixed-point scaling, selectable activation and output saturation. Sits between the layer's input/weight RAMs and the next layer's activation RAM.

---
 rtl/nn_pkg.sv | 36 +++
 rtl/neuron_activation.sv | 36 +++
 rtl/neuron_mac_stream.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/nn_pkg.sv
// Shared types and helpers for the NN layer fabric.
// Activation modes, neuron FSM states, saturation helper.
package nn_pkg;

  typedef enum logic [1:0] {
    ACTV_IDENT,
    ACTV_RELU,
    ACTV_LEAKY
  } actv_mode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HSK,
    ST_LOCK,
    ST_STREAM,
    ST_DRAIN,
    ST_ACT,
    ST_WRITE,
    ST_NOTIFY
  } st_neuron_stream_e;

  // Clip x into the signed range of a dw-bit word.
  function automatic logic signed [63:0] sat_narrow(
    input logic signed [63:0] x,
    input int                 dw
  );
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

endpackage

// File: rtl/neuron_activation.sv
// Fixed-point rescale, activation and output saturation.
// Purely combinational; the caller registers the result.
module neuron_activation
  import nn_pkg::*;
#(
  parameter int         AccWidth  = 19,
  parameter int         DataWidth = 8,
  parameter int         FracBits  = 4,
  parameter actv_mode_e ActvMode  = ACTV_RELU
) (
  input  logic signed [AccWidth-1:0]  acc_i,
  output logic signed [DataWidth-1:0] dout_o,
  output logic                        sat_o
);

  logic signed [AccWidth-1:0] y_sh;
  logic signed [AccWidth-1:0] y_act;
  logic signed [63:0]         y_wide;
  logic signed [63:0]         y_clip;

  // Drop the product's extra fraction, activate, then clip.
  always_comb begin
    y_sh  = acc_i >>> FracBits;
    y_act = y_sh;
    case (ActvMode)
      ACTV_RELU:  if (y_sh < 0) y_act = '0;
      ACTV_LEAKY: if (y_sh < 0) y_act = y_sh >>> 3;
      default:    y_act = y_sh;
    endcase
    y_wide = 64'(y_act);
    y_clip = sat_narrow(y_wide, DataWidth);
    dout_o = y_clip[DataWidth-1:0];
    sat_o  = (y_clip != y_wide);
  end

endmodule

// File: rtl/neuron_mac_stream.sv
// Streaming RAM-backed neuron: dot product + bias, activation,
// result written to the output-activation RAM.
module neuron_mac_stream
  import nn_pkg::*;
#(
  parameter int         NumInputs       = 4,
  parameter int         DataWidth       = 8,
  parameter int         FracBits        = 4,
  parameter int         NeuronsPerLayer = 5,
  parameter int         NeuronInstance  = 0,
  parameter actv_mode_e ActvMode        = ACTV_RELU,
  localparam int IAW = $clog2(NumInputs + 1),
  localparam int WAW = $clog2((NumInputs + 1) * NeuronsPerLayer),
  localparam int OAW = $clog2(NeuronsPerLayer)
) (
  input  logic                 clk_i,
  input  logic                 reset_ni,
  input  logic                 req_i,
  output logic                 ack_o,
  output logic                 req_o,
  input  logic                 ack_i,
  output logic                 in_actv_req_o,
  input  logic                 in_actv_grant_i,
  output logic [IAW-1:0]       in_actv_addr_o,
  input  logic [DataWidth-1:0] in_actv_din_i,
  output logic                 wgt_req_o,
  input  logic                 wgt_grant_i,
  output logic [WAW-1:0]       wgt_addr_o,
  input  logic [DataWidth-1:0] wgt_din_i,
  output logic                 out_actv_req_o,
  input  logic                 out_actv_grant_i,
  output logic [OAW-1:0]       out_actv_addr_o,
  output logic                 out_actv_we_o,
  output logic [DataWidth-1:0] out_actv_dout_o,
  output logic                 busy_o,
  output logic                 sat_o
);

  localparam int AW   = 2 * DataWidth + IAW;
  localparam int Base = (NumInputs + 1) * NeuronInstance;

  st_neuron_stream_e st_q;

  logic [IAW-1:0]              cnt_q;
  logic [IAW-1:0]              idx_q;
  logic                        vld_q;
  logic signed [AW-1:0]        acc_q;
  logic signed [2*DataWidth-1:0] prod;
  logic signed [AW-1:0]        term;
  logic signed [DataWidth-1:0] y_act;
  logic                        y_sat;

  assign in_actv_addr_o  = cnt_q;
  assign wgt_addr_o      = WAW'(Base) + WAW'(cnt_q);
  assign out_actv_addr_o = OAW'(NeuronInstance);
  assign busy_o          = (st_q != ST_IDLE);
  assign prod = $signed(in_actv_din_i) * $signed(wgt_din_i);

  // Last beat carries the bias, aligned to the product's fraction.
  always_comb begin
    term = AW'(prod);
    if (idx_q == IAW'(NumInputs)) begin
      term = AW'($signed(wgt_din_i)) <<< FracBits;
    end
  end

  neuron_activation #(
    .AccWidth (AW),
    .DataWidth(DataWidth),
    .FracBits (FracBits),
    .ActvMode (ActvMode)
  ) u_actv (
    .acc_i (acc_q),
    .dout_o(y_act),
    .sat_o (y_sat)
  );

  // Handshake FSM with one-beat-per-cycle MAC behind it.
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      st_q            <= ST_IDLE;
      ack_o           <= 1'b0;
      req_o           <= 1'b0;
      in_actv_req_o   <= 1'b0;
      wgt_req_o       <= 1'b0;
      out_actv_req_o  <= 1'b0;
      out_actv_we_o   <= 1'b0;
      out_actv_dout_o <= '0;
      sat_o           <= 1'b0;
      acc_q           <= '0;
      cnt_q           <= '0;
      idx_q           <= '0;
      vld_q           <= 1'b0;
    end else begin
      vld_q <= 1'b0;
      if (vld_q) acc_q <= acc_q + term;
      unique case (st_q)
        ST_IDLE: begin
          if (req_i) begin
            ack_o         <= 1'b1;
            in_actv_req_o <= 1'b1;
            wgt_req_o     <= 1'b1;
            acc_q         <= '0;
            cnt_q         <= '0;
            sat_o         <= 1'b0;
            st_q          <= ST_HSK;
          end
        end
        ST_HSK: begin
          if (!req_i) begin
            ack_o <= 1'b0;
            st_q  <= ST_LOCK;
          end
        end
        ST_LOCK: begin
          if (in_actv_grant_i && wgt_grant_i) begin
            st_q <= ST_STREAM;
          end
        end
        ST_STREAM: begin
          vld_q <= 1'b1;
          idx_q <= cnt_q;
          if (cnt_q == IAW'(NumInputs)) begin
            st_q <= ST_DRAIN;
          end else begin
            cnt_q <= cnt_q + IAW'(1);
          end
        end
        ST_DRAIN: begin
          in_actv_req_o  <= 1'b0;
          wgt_req_o      <= 1'b0;
          out_actv_req_o <= 1'b1;
          st_q           <= ST_ACT;
        end
        ST_ACT: begin
          out_actv_dout_o <= y_act;
          sat_o           <= y_sat;
          st_q            <= ST_WRITE;
        end
        ST_WRITE: begin
          if (out_actv_grant_i) begin
            out_actv_we_o <= 1'b1;
            req_o         <= 1'b1;
            st_q          <= ST_NOTIFY;
          end
        end
        ST_NOTIFY: begin
          out_actv_we_o  <= 1'b0;
          out_actv_req_o <= 1'b0;
          if (ack_i) begin
            req_o <= 1'b0;
            st_q  <= ST_IDLE;
          end
        end
        default: st_q <= ST_IDLE;
      endcase
    end
  end

endmodule
